// File: rtl/enum_seq_checker.sv
// Monitors a 2-bit enum-encoded state stream for the legal cycle A->B->C->D->A.
// It locks after LOCK_CYCLES legal advances, then flags and counts violations.
module enum_seq_checker #(
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       in_state,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       last_state,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b10,
    SYNC = 2'b00,
    LOCK = 2'b11,
    ERR  = 2'b01
  } fsm_e;

  localparam logic [1:0]       ENC_A    = 2'b11;
  localparam int               RUN_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [RUN_W-1:0] LOCK_TGT = RUN_W'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  fsm_e             state_q, state_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]       last_state_q, last_state_d;

  logic [1:0]       succ_state;
  logic             is_advance;
  logic             is_hold;
  logic [RUN_W-1:0] run_inc;

  // The encoding 11->00->01->10->11 happens to be a 2-bit increment.
  assign succ_state = last_state_q + 2'b01;
  assign is_advance = (in_state == succ_state);
  assign is_hold    = (in_state == last_state_q);
  assign run_inc    = run_cnt_q + RUN_W'(1);

  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    err_d        = 1'b0;
    err_cnt_d    = err_cnt_q;
    last_state_d = last_state_q;

    if (clr) begin
      state_d   = IDLE;
      run_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if (in_valid) begin
        last_state_d = in_state;
      end

      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d   = SYNC;
            run_cnt_d = '0;
          end
        end
        SYNC: begin
          if (in_valid) begin
            if (is_advance) begin
              if (run_inc == LOCK_TGT) begin
                state_d   = LOCK;
                run_cnt_d = '0;
              end else begin
                run_cnt_d = run_inc;
              end
            end else if (!is_hold) begin
              run_cnt_d = '0;
            end
          end
        end
        LOCK: begin
          if (in_valid && !is_advance && !is_hold) begin
            state_d = ERR;
            err_d   = 1'b1;
            if (err_cnt_q != CNT_MAX) begin
              err_cnt_d = err_cnt_q + CNT_W'(1);
            end
          end
        end
        ERR: begin
          // A sample taken here only seeds last_state for the next sync run.
          state_d   = SYNC;
          run_cnt_d = '0;
        end
        default: begin
          state_d   = IDLE;
          run_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      run_cnt_q    <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      last_state_q <= ENC_A;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
      last_state_q <= last_state_d;
    end
  end

  assign locked     = (state_q == LOCK);
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;
  assign last_state = last_state_q;
  assign fsm_state  = state_q;

endmodule

// File: doc/enum_seq_checker.md
Name: enum_seq_checker

Overview:
- Downstream monitor for a 2-bit enum-encoded FSM state stream with non-sequential encoding.
- Encoding: A=2'b11, B=2'b00, C=2'b01, D=2'b10.
- Checks that the stream follows the legal cycle A→B→C→D→A, locks after a run of legal advances, and flags and counts violations once locked.
- Its own control FSM uses an explicit non-default enum encoding, exposed on a port so the frontend's enum value handling is observable.

Parameters:
- CNT_W, 8: width of the saturating violation counter.
- LOCK_CYCLES, 4: number of consecutive legal advances needed to enter LOCK; legal range ≥1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_state is sampled this cycle
- in_state  in  2  observed state (A=11, B=00, C=01, D=10)
- clr  in  1  synchronous clear of counter and FSM
- locked  out  1  high while the checker FSM is in LOCK
- err  out  1  one-cycle pulse on a violation detected in LOCK
- err_cnt  out  CNT_W  saturating violation count
- last_state  out  2  most recently accepted in_state
- fsm_state  out  2  checker FSM encoding: IDLE=2'b10, SYNC=2'b00, LOCK=2'b11, ERR=2'b01

Behaviour:
- Reset (rst_n low, asynchronous):
  - fsm_state=IDLE (2'b10), locked=0, err=0, err_cnt=0.
  - last_state=A (2'b11), internal run_cnt=0.
- All outputs are registered; every response appears the cycle after the sampling edge.
- succ(x): A→B, B→C, C→D, D→A, computed on the encoded values: 11→00→01→10→11.
- Each in_valid sample is classified against last_state:
  - advance: in_state == succ(last_state)
  - hold: in_state == last_state
  - illegal: anything else
- last_state updates to in_state on every accepted in_valid, whatever the classification and FSM state, except when clr wins.
- IDLE: in_valid → go to SYNC, run_cnt=0. No classification is made.
- SYNC:
  - advance: run_cnt+1. If run_cnt+1 == LOCK_CYCLES, go to LOCK and set locked=1 on the same edge.
  - hold: no change.
  - illegal: run_cnt=0, stay in SYNC, no err, no count.
- LOCK:
  - advance or hold: stay in LOCK.
  - illegal: go to ERR, locked=0, err=1 for exactly one cycle, err_cnt+1.
- ERR: lasts exactly one cycle, then go to SYNC with run_cnt=0. An in_valid during ERR updates last_state only (it becomes the sync seed). It is not classified.
- err_cnt saturates at 2^CNT_W-1 and never wraps.
- clr (synchronous) has highest priority:
  - Next state is fsm_state=IDLE, err_cnt=0, locked=0, err=0, run_cnt=0.
  - last_state is unchanged.
  - A concurrent in_valid is ignored, including a concurrent violation: no err pulse, no count.
- in_valid low: no state changes. ERR→SYNC still proceeds.
- rst_n asserted mid-run returns everything to reset values immediately, with no dependence on clk.

Test Plan:
1. Reset, then valid stream A,B,C,D,A (LOCK_CYCLES=4):
   - fsm_state 10→00 after the first A; locked=1 the cycle after the 4th advance (the second A).
   - err=0, err_cnt=0.
2. Locked, then stream B,B,B,C (holds):
   - locked stays 1, err never pulses.
   - last_state ends 2'b01.
3. Locked at C, send A (illegal):
   - Next cycle: err=1 for one cycle, err_cnt=1, fsm_state=01, locked=0.
   - Following cycle: fsm_state=00.
   - Four further advances relock.
4. CNT_W=2; repeatedly lock then violate 5 times:
   - err_cnt reads 1,2,3,3,3.
   - err still pulses on every violation.
5. Locked; assert clr in the same cycle as an illegal in_state:
   - Next cycle: fsm_state=10, err_cnt=0, err=0, locked=0.
   - last_state is unchanged from its pre-clr value.
6. In SYNC with run_cnt=2, drop rst_n between clock edges:
   - Outputs go to reset values immediately (fsm_state=10, last_state=11).
   - After release, resync requires a fresh 4 advances.
